// File: rtl/top_decoder.sv
// top_decoder: signed binary to registered three-digit seven-segment display
module top_decoder #(
    parameter int DW_IN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW_IN-1:0] number,
    output logic             sign,
    output logic [6:0]       segments_hundreds,
    output logic [6:0]       segments_tens,
    output logic [6:0]       segments_units
);
    localparam logic [6:0] BLANK = 7'h7F;

    logic [DW_IN-1:0] mag;
    logic [11:0]      bcd;
    logic             sign_d, sign_q;
    logic [6:0]       hund_d, hund_q, tens_d, tens_q, units_d, units_q;

    // Active-low {g,f,e,d,c,b,a}; codes 10..15 cannot occur and show blank
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h40;
            4'd1: seg7 = 7'h79;
            4'd2: seg7 = 7'h24;
            4'd3: seg7 = 7'h30;
            4'd4: seg7 = 7'h19;
            4'd5: seg7 = 7'h12;
            4'd6: seg7 = 7'h02;
            4'd7: seg7 = 7'h78;
            4'd8: seg7 = 7'h00;
            4'd9: seg7 = 7'h10;
            default: seg7 = BLANK;
        endcase
    endfunction

    // Magnitude (most-negative value maps to 2^(DW_IN-1) unsigned) then shift-add-3 to BCD
    always_comb begin
        sign_d = number[DW_IN-1];
        mag    = sign_d ? ~number + DW_IN'(1) : number;
        bcd    = '0;
        for (int i = DW_IN - 1; i >= 0; i--) begin
            bcd[3:0]  = bcd[3:0]  >= 4'd5 ? bcd[3:0]  + 4'd3 : bcd[3:0];
            bcd[7:4]  = bcd[7:4]  >= 4'd5 ? bcd[7:4]  + 4'd3 : bcd[7:4];
            bcd[11:8] = bcd[11:8] >= 4'd5 ? bcd[11:8] + 4'd3 : bcd[11:8];
            bcd       = {bcd[10:0], mag[i]};
        end
        hund_d  = seg7(bcd[11:8]);
        tens_d  = seg7(bcd[7:4]);
        units_d = seg7(bcd[3:0]);
    end

    // Output registers: one-cycle latency, blanked while in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q  <= 1'b0;
            hund_q  <= BLANK;
            tens_q  <= BLANK;
            units_q <= BLANK;
        end else begin
            sign_q  <= sign_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign sign              = sign_q;
    assign segments_hundreds = hund_q;
    assign segments_tens     = tens_q;
    assign segments_units    = units_q;
endmodule

// File: tb/tb_top_decoder.sv
// tb_top_decoder: directed-vector self-checking bench for top_decoder (DW_IN=8 and DW_IN=10)
module tb_top_decoder;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] number;
    logic [9:0] number10;
    logic       sign, sign10;
    logic [6:0] h, t, u, h10, t10, u10;
    int         errors = 0;
    int         checks = 0;

    top_decoder #(.DW_IN(8)) dut (
        .clk(clk), .rst(rst), .number(number), .sign(sign),
        .segments_hundreds(h), .segments_tens(t), .segments_units(u)
    );

    top_decoder #(.DW_IN(10)) dut10 (
        .clk(clk), .rst(rst), .number(number10), .sign(sign10),
        .segments_hundreds(h10), .segments_tens(t10), .segments_units(u10)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input int d);
        logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[d];
    endfunction

    function automatic logic [21:0] ref_out(input int v);
        int m;
        m = v < 0 ? -v : v;
        return {v < 0, ref_seg(m / 100), ref_seg((m / 10) % 10), ref_seg(m % 10)};
    endfunction

    function automatic logic [21:0] out8();
        return {sign, h, t, u};
    endfunction

    function automatic logic [21:0] out10();
        return {sign10, h10, t10, u10};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [21:0] BLANK_OUT = {1'b0, 7'h7F, 7'h7F, 7'h7F};

    initial begin
        rst = 1'b1; number = 8'h05; number10 = 10'h005;
        tick();
        check("reset_cycle1", out8(), BLANK_OUT);
        tick();
        check("reset_cycle2", out8(), BLANK_OUT);
        check("reset_dw10", out10(), BLANK_OUT);
        rst = 1'b0;
        tick();
        check("release_5", out8(), {1'b0, 7'h40, 7'h40, 7'h12});
        number = 8'h80;
        #2;
        check("latency_hold", out8(), {1'b0, 7'h40, 7'h40, 7'h12});
        tick();
        check("neg128", out8(), {1'b1, 7'h79, 7'h24, 7'h00});
        number = 8'h7F;
        tick();
        check("pos127", out8(), {1'b0, 7'h79, 7'h24, 7'h78});
        number = 8'hFF;
        tick();
        check("neg1", out8(), {1'b1, 7'h40, 7'h40, 7'h79});
        number = 8'h00;
        tick();
        check("zero", out8(), {1'b0, 7'h40, 7'h40, 7'h40});
        number = 8'hC8;
        tick();
        check("neg56", out8(), {1'b1, 7'h40, 7'h12, 7'h02});
        number = 8'h5D;
        tick();
        check("pos93", out8(), {1'b0, 7'h40, 7'h10, 7'h30});
        number = 8'h7F; rst = 1'b1;
        tick();
        check("midstream_reset", out8(), BLANK_OUT);
        rst = 1'b0; number = 8'h2A;
        tick();
        check("after_reset_42", out8(), {1'b0, 7'h40, 7'h19, 7'h24});
        number10 = 10'h200;
        tick();
        check("dw10_neg512", out10(), {1'b1, 7'h12, 7'h79, 7'h24});
        number10 = 10'h1FF;
        tick();
        check("dw10_pos511", out10(), {1'b0, 7'h12, 7'h79, 7'h79});
        number10 = 10'h3E7;
        tick();
        check("dw10_neg25", out10(), {1'b1, 7'h40, 7'h24, 7'h12});
        for (int v = -128; v <= 127; v++) begin
            number = 8'(v);
            tick();
            check($sformatf("sweep_%0d", v), out8(), ref_out(v));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
